// File: rtl/ram_filler.sv
// Sequential memory filler: walks START_ADDR..END_ADDR, one wr strobe per location, paced by ena.
// Mode 11 produces a Galois LFSR sequence only when RAM_FILLER_LFSR_EN is defined; otherwise it fills with the pattern value.
module ram_filler #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              trigger,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              done
);

  if (END_ADDR < START_ADDR) begin : g_bad_order
    $error("ram_filler: END_ADDR must not be below START_ADDR");
  end
  if (ADDR_W < 31 && END_ADDR >= (1 << ADDR_W)) begin : g_bad_width
    $error("ram_filler: END_ADDR does not fit in ADDR_W bits");
  end

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, GAP} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              trig_q, trig_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [ADDR_W-1:0] addr_nxt;

  assign addr_nxt = addr_q + ADDR_W'(1);

  // Non-LFSR patterns; mode 11 falls back to the constant pattern.
  function automatic logic [DATA_W-1:0] pat_value(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] p,
                                                  input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    case (m)
      2'b01:   v = DATA_W'(a);
      2'b10:   v = a[0] ? ~p : p;
      default: v = p;
    endcase
    return v;
  endfunction

`ifdef RAM_FILLER_LFSR_EN
  // Right-shifting Galois feedback masks for maximal-length sequences.
  function automatic logic [DATA_W-1:0] lfsr_taps();
    case (DATA_W)
      3:       return DATA_W'('h6);
      4:       return DATA_W'('hC);
      5:       return DATA_W'('h14);
      6:       return DATA_W'('h30);
      7:       return DATA_W'('h60);
      8:       return DATA_W'('hB8);
      16:      return DATA_W'('hB400);
      default: return '0;
    endcase
  endfunction

  localparam logic [DATA_W-1:0] TAPS = lfsr_taps();
  if (TAPS == '0) begin : g_bad_lfsr
    $error("ram_filler: no LFSR polynomial for this DATA_W");
  end

  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] lfsr_nxt;

  assign seed     = (pattern == '0) ? DATA_W'(1) : pattern;
  assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    trig_d  = trigger;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
`ifdef RAM_FILLER_LFSR_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (trigger && !trig_q) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          wr_d    = 1'b0;
          addr_d  = START_A;
          mode_d  = mode;
          pat_d   = pattern;
          data_d  = pat_value(mode, pattern, START_A);
`ifdef RAM_FILLER_LFSR_EN
          lfsr_d  = seed;
          if (mode == 2'b11) data_d = seed;
`endif
        end
      end
      SETUP: begin
        if (ena) begin
          state_d = WRITE;
          wr_d    = 1'b1;
        end
      end
      WRITE: begin
        if (ena) begin
          state_d = GAP;
          wr_d    = 1'b0;
        end
      end
      GAP: begin
        if (ena) begin
          if (addr_q == END_A) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Address and data move on the same edge wr rises, so both are stable for the whole strobe.
            state_d = WRITE;
            wr_d    = 1'b1;
            addr_d  = addr_nxt;
            data_d  = pat_value(mode_q, pat_q, addr_nxt);
`ifdef RAM_FILLER_LFSR_EN
            lfsr_d  = lfsr_nxt;
            if (mode_q == 2'b11) data_d = lfsr_nxt;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b1;
      addr_q  <= START_A;
      data_q  <= '0;
      mode_q  <= 2'b00;
      pat_q   <= '0;
`ifdef RAM_FILLER_LFSR_EN
      lfsr_q  <= DATA_W'(1);
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
`ifdef RAM_FILLER_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign busy = busy_q;
  assign wr   = wr_q;
  assign addr = addr_q;
  assign data = data_q;
  assign done = done_q;

endmodule

// File: tb/tb_ram_filler.sv
// Directed bench for ram_filler: ADDR_W=4, DATA_W=8, addresses 2..5, ena every second clock.
module tb_ram_filler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       trigger = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] pattern = 8'h00;
  logic       busy, wr, done;
  logic [3:0] addr;
  logic [7:0] data;

  ram_filler #(.ADDR_W(4), .DATA_W(8), .START_ADDR(2), .END_ADDR(5)) dut (
    .clk(clk), .reset(reset), .ena(ena), .trigger(trigger), .mode(mode),
    .pattern(pattern), .busy(busy), .wr(wr), .addr(addr), .data(data), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 ena = ~ena;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Write monitor, sampled on the falling edge.
  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int   n_done = 0, ticks = 0, unstable = 0;
  logic wr_prev = 1'b0;
  logic [3:0] hold_a;
  logic [7:0] hold_d;

  always @(negedge clk) begin
    if (wr && wr_prev && (addr !== hold_a || data !== hold_d)) unstable++;
    if (wr && !wr_prev) begin
      wa.push_back(addr);
      wd.push_back(data);
      hold_a = addr;
      hold_d = data;
    end
    wr_prev = wr;
    if (done) n_done++;
    if (busy && ena) ticks++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    n_done = 0;
    ticks = 0;
    unstable = 0;
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_fill(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_d[4];
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
    chk({tag, "_nwr"}, 32'(wa.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(i + 2));
        chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(exp_d[i]));
      end
    end
    chk({tag, "_ndone"}, 32'(n_done), 32'd1);
    chk({tag, "_ticks"}, 32'(ticks), 32'd9);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stable"}, 32'(unstable), 32'd0);
  endtask

  task automatic run_fill(input string tag, input logic [1:0] m, input logic [7:0] p,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    clear_mon();
    mode = m;
    pattern = p;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    mode = ~m;
    pattern = ~p;
    wait_done(tag);
    repeat (6) tick();
    check_fill(tag, e0, e1, e2, e3);
  endtask

  initial begin
    logic hit;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(addr), 32'd2);
    chk("rst_data", 32'(data), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    run_fill("m00", 2'b00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
    run_fill("m01", 2'b01, 8'h77, 8'h02, 8'h03, 8'h04, 8'h05);
    run_fill("m10", 2'b10, 8'h0F, 8'h0F, 8'hF0, 8'h0F, 8'hF0);
`ifdef RAM_FILLER_LFSR_EN
    run_fill("m11", 2'b11, 8'h00, 8'h01, 8'hB8, 8'h5C, 8'h2E);
`else
    run_fill("m11", 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    // Second trigger edge during the addr 3 write must be ignored.
    clear_mon();
    mode = 2'b00;
    pattern = 8'h3C;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr && addr == 4'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("retrig_reach", 32'(hit), 32'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_done("retrig");
    repeat (30) tick();
    check_fill("retrig", 8'h3C, 8'h3C, 8'h3C, 8'h3C);

    // Reset during the addr 4 gap, trigger held high across release.
    clear_mon();
    mode = 2'b01;
    pattern = 8'h00;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && !wr && addr == 4'd4 && wa.size() == 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reach", 32'(hit), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_wr", 32'(wr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(addr), 32'd2);
    chk("abort_data", 32'(data), 32'd0);
    trigger = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    clear_mon();
    repeat (20) tick();
    chk("held_nwr", 32'(wa.size()), 32'd0);
    chk("held_busy", 32'(busy), 32'd0);
    trigger = 1'b0;
    tick();
    clear_mon();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_done("refill");
    repeat (6) tick();
    check_fill("refill", 8'h02, 8'h03, 8'h04, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
